// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Shares the single off-chip memory port between the I-cache and the D-cache.
// One requester owns the bus per transaction. The D-cache wins ties by
// default, but a saturating streak counter forces an I-cache grant after
// MAX_D_STREAK consecutive D grants while the I-cache was waiting.
//
// Optional build macro: ARB_PERF_EN adds per-requester wait-cycle counters
// on the extra outputs i_wait_cnt / d_wait_cnt.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   i_mem_* (read/write/addr/wdata in, rdata/ready out)   I-cache side
//   d_mem_* (read/write/addr/wdata in, rdata/ready out)   D-cache side
//   mem_* (read/write/addr/wdata out, rdata/ready in)     memory side
//   grant_i, grant_d            current bus owner
//   i_wait_cnt, d_wait_cnt      wait-cycle counters (ARB_PERF_EN only)
//
// state | meaning
// IDLE  | bus free, arbitrate between active requesters
// GNT_I | I-cache owns the bus until mem_ready or request drop
// GNT_D | D-cache owns the bus until mem_ready or request drop
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int ADDR_W       = 28,
  parameter int DATA_W       = 128,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              grant_i,
  output logic              grant_d
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]       i_wait_cnt,
  output logic [31:0]       d_wait_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

  state_t     state, state_nxt;
  logic [3:0] streak, streak_nxt;
  logic       i_act, d_act;

  assign i_act = i_mem_read | i_mem_write;
  assign d_act = d_mem_read | d_mem_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    unique case (state)
      IDLE: begin
        if (d_act && (!i_act || streak < MAX_S)) begin
          state_nxt = GNT_D;
          if (i_act && streak < MAX_S) streak_nxt = streak + 4'd1;
        end else if (i_act) begin
          state_nxt  = GNT_I;
          streak_nxt = '0;
        end
      end
      // A dropped request without mem_ready is a protocol violation; release
      // the bus so the other requester is not locked out.
      GNT_I: if (mem_ready || !i_act) state_nxt = IDLE;
      GNT_D: if (mem_ready || !d_act) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == GNT_I) begin
      mem_read  = i_mem_read;
      mem_write = i_mem_write;
      mem_addr  = i_mem_addr;
      mem_wdata = i_mem_wdata;
    end else if (state == GNT_D) begin
      mem_read  = d_mem_read;
      mem_write = d_mem_write;
      mem_addr  = d_mem_addr;
      mem_wdata = d_mem_wdata;
    end
  end

  // State is a register, so the grants are glitch-free registered outputs.
  assign grant_i = (state == GNT_I);
  assign grant_d = (state == GNT_D);

  assign i_mem_ready = mem_ready & (state == GNT_I);
  assign d_mem_ready = mem_ready & (state == GNT_D);
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

`ifdef ARB_PERF_EN
  // The arbitration cycle in which a requester wins is not counted as a
  // wait: only cycles spent behind the other requester (or losing the
  // tie) accumulate.
  logic i_wait, d_wait;
  assign i_wait = i_act && (state != GNT_I) && (state_nxt != GNT_I);
  assign d_wait = d_act && (state != GNT_D) && (state_nxt != GNT_D);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_wait_cnt <= '0;
      d_wait_cnt <= '0;
    end else begin
      if (i_wait) i_wait_cnt <= i_wait_cnt + 32'd1;
      if (d_wait) d_wait_cnt <= d_wait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_mem_read, i_mem_write;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [DATA_W-1:0] i_mem_wdata, i_mem_rdata;
  logic              i_mem_ready;
  logic              d_mem_read, d_mem_write;
  logic [ADDR_W-1:0] d_mem_addr;
  logic [DATA_W-1:0] d_mem_wdata, d_mem_rdata;
  logic              d_mem_ready;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_ready;
  logic              grant_i, grant_d;
`ifdef ARB_PERF_EN
  logic [31:0]       i_wait_cnt, d_wait_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
`ifdef ARB_PERF_EN
    .i_wait_cnt(i_wait_cnt), .d_wait_cnt(d_wait_cnt),
`endif
    .grant_i(grant_i), .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_mem_read = 0; i_mem_write = 0; i_mem_addr = '0; i_mem_wdata = '0;
    d_mem_read = 0; d_mem_write = 0; d_mem_addr = '0; d_mem_wdata = '0;
    mem_rdata = '0; mem_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    wait_edge();
    wait_edge();
    n_checks++;
    if ({mem_read, mem_write, grant_i, grant_d, i_mem_ready, d_mem_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want 000000",
               {mem_read, mem_write, grant_i, grant_d, i_mem_ready, d_mem_ready});
    end
    n_checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: got addr %h wdata %h want 0", mem_addr, mem_wdata);
    end
    n_checks++;
    if (dut.streak !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_streak: got %0d want 0", dut.streak);
    end
    rst_n = 1;
    wait_edge();
  endtask

  task automatic test_i_read();
    i_mem_read = 1; i_mem_addr = 28'h0000010;
    #1;
    n_checks++;
    if (grant_i !== 1'b0 || mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL i_read_idle: got grant_i %b mem_read %b want 0 0", grant_i, mem_read);
    end
    wait_edge();
    n_checks++;
    if (grant_i !== 1'b1 || grant_d !== 1'b0 || mem_read !== 1'b1 || mem_addr !== 28'h0000010) begin
      n_fail++;
      $display("FAIL i_read_grant: got gi %b gd %b rd %b addr %h want 1 0 1 0000010",
               grant_i, grant_d, mem_read, mem_addr);
    end
    for (int c = 0; c < 4; c++) begin
      wait_edge();
      n_checks++;
      if (i_mem_ready !== 1'b0 || grant_i !== 1'b1) begin
        n_fail++;
        $display("FAIL i_read_wait%0d: got ready %b grant %b want 0 1", c, i_mem_ready, grant_i);
      end
    end
    mem_ready = 1; mem_rdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    #1;
    n_checks++;
    if (i_mem_ready !== 1'b1 || d_mem_ready !== 1'b0 ||
        i_mem_rdata !== 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210) begin
      n_fail++;
      $display("FAIL i_read_done: got ir %b dr %b data %h want 1 0 0123..3210",
               i_mem_ready, d_mem_ready, i_mem_rdata);
    end
    wait_edge();
    mem_ready = 0; i_mem_read = 0;
    #1;
    n_checks++;
    if (grant_i !== 1'b0 || mem_read !== 1'b0 || i_mem_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL i_read_idle_after: got gi %b rd %b ir %b want 0 0 0",
               grant_i, mem_read, i_mem_ready);
    end
  endtask

  task automatic test_simultaneous();
    d_mem_write = 1; d_mem_addr = 28'h00000A0;
    d_mem_wdata = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    i_mem_read = 1; i_mem_addr = 28'h0000020;
    wait_edge();
    n_checks++;
    if (grant_d !== 1'b1 || grant_i !== 1'b0 || mem_write !== 1'b1 || mem_read !== 1'b0 ||
        mem_addr !== 28'h00000A0 || mem_wdata !== 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF) begin
      n_fail++;
      $display("FAIL sim_d_first: got gd %b gi %b wr %b rd %b addr %h wdata %h want 1 0 1 0 00000a0 dead..beef",
               grant_d, grant_i, mem_write, mem_read, mem_addr, mem_wdata);
    end
    n_checks++;
    if (dut.streak !== 4'd1) begin
      n_fail++;
      $display("FAIL sim_streak1: got %0d want 1", dut.streak);
    end
    mem_ready = 1;
    #1;
    n_checks++;
    if (d_mem_ready !== 1'b1 || i_mem_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_d_ready: got dr %b ir %b want 1 0", d_mem_ready, i_mem_ready);
    end
    wait_edge();
    mem_ready = 0; d_mem_write = 0;
    #1;
    n_checks++;
    if (grant_d !== 1'b0 || grant_i !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_bubble: got gd %b gi %b want 0 0", grant_d, grant_i);
    end
    wait_edge();
    n_checks++;
    if (grant_i !== 1'b1 || mem_addr !== 28'h0000020 || mem_read !== 1'b1 || dut.streak !== 4'd0) begin
      n_fail++;
      $display("FAIL sim_i_second: got gi %b addr %h rd %b streak %0d want 1 0000020 1 0",
               grant_i, mem_addr, mem_read, dut.streak);
    end
    mem_ready = 1;
    wait_edge();
    mem_ready = 0; i_mem_read = 0;
    wait_edge();
  endtask

  task automatic test_starvation();
    logic [5:0] exp_d;
    exp_d = 6'b101111;  // bit k: grant k goes to D
    i_mem_read = 1; i_mem_addr = 28'h0000100;
    d_mem_read = 1; d_mem_addr = 28'h0000200;
    for (int k = 0; k < 6; k++) begin
      wait_edge();
      n_checks++;
      if (grant_d !== exp_d[k] || grant_i !== !exp_d[k]) begin
        n_fail++;
        $display("FAIL starve_grant%0d: got gd %b gi %b want %b %b",
                 k, grant_d, grant_i, exp_d[k], !exp_d[k]);
      end
      mem_ready = 1;
      #1;
      n_checks++;
      if (d_mem_ready !== exp_d[k] || i_mem_ready !== !exp_d[k]) begin
        n_fail++;
        $display("FAIL starve_ready%0d: got dr %b ir %b want %b %b",
                 k, d_mem_ready, i_mem_ready, exp_d[k], !exp_d[k]);
      end
      wait_edge();
      mem_ready = 0;
      if (k == 4) i_mem_read = 0;
      if (k == 5) d_mem_read = 0;
    end
    n_checks++;
    if (dut.streak !== 4'd0) begin
      n_fail++;
      $display("FAIL starve_streak_end: got %0d want 0", dut.streak);
    end
    wait_edge();
  endtask

  task automatic test_stray_ready();
    mem_ready = 1;
    #1;
    n_checks++;
    if (i_mem_ready !== 1'b0 || d_mem_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_idle_ready: got ir %b dr %b want 0 0", i_mem_ready, d_mem_ready);
    end
    wait_edge();
    mem_ready = 0;
    n_checks++;
    if (grant_i !== 1'b0 || grant_d !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_idle_grant: got gi %b gd %b want 0 0", grant_i, grant_d);
    end
    d_mem_read = 1; d_mem_addr = 28'h0000300;
    wait_edge();
    for (int c = 0; c < 4; c++) begin
      i_mem_read = ~i_mem_read;
      #1;
      n_checks++;
      if (grant_d !== 1'b1 || grant_i !== 1'b0 || i_mem_ready !== 1'b0 || mem_addr !== 28'h0000300) begin
        n_fail++;
        $display("FAIL stray_toggle%0d: got gd %b gi %b ir %b addr %h want 1 0 0 0000300",
                 c, grant_d, grant_i, i_mem_ready, mem_addr);
      end
      wait_edge();
    end
    mem_ready = 1;
    #1;
    n_checks++;
    if (d_mem_ready !== 1'b1 || i_mem_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_d_done: got dr %b ir %b want 1 0", d_mem_ready, i_mem_ready);
    end
    wait_edge();
    mem_ready = 0; d_mem_read = 0;
    wait_edge();
  endtask

  task automatic test_drop();
    i_mem_read = 1; i_mem_addr = 28'h0000400;
    wait_edge();
    i_mem_read = 0;
    #1;
    n_checks++;
    if (grant_i !== 1'b1 || i_mem_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_held: got gi %b ir %b want 1 0", grant_i, i_mem_ready);
    end
    wait_edge();
    n_checks++;
    if (grant_i !== 1'b0 || mem_read !== 1'b0 || i_mem_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_release: got gi %b rd %b ir %b want 0 0 0", grant_i, mem_read, i_mem_ready);
    end
  endtask

  task automatic test_mid_reset();
    i_mem_read = 1; i_mem_addr = 28'h0000500;
    d_mem_read = 1; d_mem_write = 1; d_mem_addr = 28'h0000600;
    wait_edge();
    n_checks++;
    if (grant_d !== 1'b1 || mem_read !== 1'b1 || mem_write !== 1'b1 || dut.streak !== 4'd1) begin
      n_fail++;
      $display("FAIL mrst_pre: got gd %b rd %b wr %b streak %0d want 1 1 1 1",
               grant_d, mem_read, mem_write, dut.streak);
    end
    #2;
    rst_n = 0;
    #1;
    n_checks++;
    if (grant_d !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || dut.streak !== 4'd0) begin
      n_fail++;
      $display("FAIL mrst_async: got gd %b rd %b wr %b streak %0d want 0 0 0 0",
               grant_d, mem_read, mem_write, dut.streak);
    end
    i_mem_read = 0; d_mem_read = 0; d_mem_write = 0;
    wait_edge();
    rst_n = 1;
    wait_edge();
    i_mem_read = 1; i_mem_addr = 28'h0000700;
    wait_edge();
    n_checks++;
    if (grant_i !== 1'b1 || mem_addr !== 28'h0000700 || mem_read !== 1'b1) begin
      n_fail++;
      $display("FAIL mrst_fresh_i: got gi %b addr %h rd %b want 1 0000700 1", grant_i, mem_addr, mem_read);
    end
    mem_ready = 1;
    #1;
    n_checks++;
    if (i_mem_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mrst_fresh_ready: got %b want 1", i_mem_ready);
    end
    wait_edge();
    mem_ready = 0; i_mem_read = 0;
    wait_edge();
  endtask

`ifdef ARB_PERF_EN
  task automatic test_perf();
    rst_n = 0;
    #1;
    rst_n = 1;
    wait_edge();
    d_mem_read = 1; i_mem_read = 1;
    wait_edge();
    for (int c = 0; c < 5; c++) wait_edge();
    mem_ready = 1;
    wait_edge();
    mem_ready = 0; d_mem_read = 0;
    wait_edge();
    n_checks++;
    if (i_wait_cnt !== 32'd7 || d_wait_cnt !== 32'd0 || grant_i !== 1'b1) begin
      n_fail++;
      $display("FAIL perf_cnt: got i %0d d %0d gi %b want 7 0 1", i_wait_cnt, d_wait_cnt, grant_i);
    end
    mem_ready = 1;
    wait_edge();
    mem_ready = 0; i_mem_read = 0;
    wait_edge();
  endtask
`endif

  initial begin
    test_reset();
    test_i_read();
    test_simultaneous();
    test_starvation();
    test_stray_ready();
    test_drop();
    test_mid_reset();
`ifdef ARB_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
